// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (CPU / debug) arbiter in front of one single-port RAM.
//            Round-robin on contested requests and back-to-back hand-over from
//            RESP straight into GRANT. Keeps a saturating count of contested
//            arbitrations.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   conflict_cnt
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_GRANT = 2'd1;
  localparam logic [1:0] c_RESP  = 2'd2;

  localparam logic c_CPU = 1'b0;
  localparam logic c_DBG = 1'b1;

  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_owner;
  logic        w_owner_nxt;
  logic        r_last_owner;
  logic        w_last_owner_nxt;
  logic [15:0] r_conflict_cnt;
  logic [15:0] w_conflict_cnt_nxt;
  logic        w_conflict;
  logic        w_other_req;

  // Request of whichever port does not currently own the RAM.
  assign w_other_req = (r_owner == c_DBG) ? cpu_req : dbg_req;

  // Saturating contest counter: freezes at all-ones instead of wrapping.
  assign w_conflict_cnt_nxt = (w_conflict && (r_conflict_cnt != c_CNT_MAX))
                              ? r_conflict_cnt + 16'd1 : r_conflict_cnt;

  // State register: FSM, ownership and contest counter, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= c_IDLE;
      r_owner        <= c_CPU;
      r_last_owner   <= c_DBG;
      r_conflict_cnt <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_owner        <= w_owner_nxt;
      r_last_owner   <= w_last_owner_nxt;
      r_conflict_cnt <= w_conflict_cnt_nxt;
    end
  end

  // Next-state logic: arbitration in IDLE, direct hand-over from RESP.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_conflict       = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (cpu_req && dbg_req) begin
          // Contested: the port that was served last loses.
          w_owner_nxt = ~r_last_owner;
          w_conflict  = 1'b1;
          w_state_nxt = c_GRANT;
        end else if (cpu_req) begin
          w_owner_nxt = c_CPU;
          w_state_nxt = c_GRANT;
        end else if (dbg_req) begin
          w_owner_nxt = c_DBG;
          w_state_nxt = c_GRANT;
        end
      end
      c_GRANT: begin
        // Access is committed once granted; a dropped req does not abort it.
        w_state_nxt = c_RESP;
      end
      c_RESP: begin
        w_last_owner_nxt = r_owner;
        // The owner's own req is still high here and must not re-win.
        if (w_other_req) begin
          w_owner_nxt = ~r_owner;
          w_conflict  = 1'b1;
          w_state_nxt = c_GRANT;
        end else begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic: RAM drive from owner, one-cycle ack with gated read data.
  always_comb begin
    mem_addr  = (r_owner == c_DBG) ? dbg_addr  : cpu_addr;
    mem_wdata = (r_owner == c_DBG) ? dbg_wdata : cpu_wdata;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    cpu_rdata = '0;
    dbg_rdata = '0;
    if (r_state == c_GRANT) begin
      mem_we = (r_owner == c_DBG) ? dbg_we : cpu_we;
    end
    if (r_state == c_RESP) begin
      if (r_owner == c_DBG) begin
        dbg_ack   = 1'b1;
        dbg_rdata = mem_rdata;
      end else begin
        cpu_ack   = 1'b1;
        cpu_rdata = mem_rdata;
      end
    end
  end

  assign cpu_stall    = cpu_req & ~cpu_ack;
  assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ack, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard queues (filled by stimulus) and shadow memory.
  txn_t        q_cpu[$];
  txn_t        q_dbg[$];
  logic [31:0] sh[256];
  logic [31:0] ram[256];

  // Reference model: time-stamped schedule of acks.
  int          cyc = 0;
  int          m_ack_cyc = -1;
  logic        m_cur = 1'b0;
  logic        m_last = 1'b1;
  logic [15:0] m_cnt = '0;
  logic        e_cpu, e_dbg;

  mem_arbiter #(.AW(8), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 8'h10) return 32'hDEADBEEF;
    return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Synchronous RAM: one-cycle read latency; reloaded with known contents in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Pop the acked transaction and check read data against the shadow memory.
  task automatic score(input logic sel, input logic [31:0] rdata);
    txn_t t;
    if (sel ? (q_dbg.size() == 0) : (q_cpu.size() == 0)) begin
      chk(sel ? "dbg_unexpected_ack" : "cpu_unexpected_ack", 1, 0);
      return;
    end
    t = sel ? q_dbg.pop_front() : q_cpu.pop_front();
    if (t.we) sh[t.addr] = t.data;
    else chk(sel ? "dbg_rdata" : "cpu_rdata", rdata, sh[t.addr]);
  endtask

  // Monitor + model: compare on the falling edge, then advance on this cycle's inputs.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_ack_cyc = -1;
      m_cur     = 1'b0;
      m_last    = 1'b1;
      m_cnt     = '0;
      q_cpu.delete();
      q_dbg.delete();
      for (int i = 0; i < 256; i++) sh[i] = init_word(i);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_dbg_ack", dbg_ack, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_cnt", conflict_cnt, 0);
    end else begin
      e_cpu = (cyc == m_ack_cyc) && !m_cur;
      e_dbg = (cyc == m_ack_cyc) && m_cur;
      chk("cpu_ack", cpu_ack, e_cpu);
      chk("dbg_ack", dbg_ack, e_dbg);
      chk("conflict_cnt", conflict_cnt, m_cnt);
      chk("cpu_stall", cpu_stall, cpu_req & ~e_cpu);
      if (cyc == m_ack_cyc - 1) begin
        if (!m_cur && q_cpu.size() > 0) begin
          chk("grant_we", mem_we, q_cpu[0].we);
          chk("grant_addr", mem_addr, q_cpu[0].addr);
          if (q_cpu[0].we) chk("grant_wdata", mem_wdata, q_cpu[0].data);
        end else if (m_cur && q_dbg.size() > 0) begin
          chk("grant_we", mem_we, q_dbg[0].we);
          chk("grant_addr", mem_addr, q_dbg[0].addr);
          if (q_dbg[0].we) chk("grant_wdata", mem_wdata, q_dbg[0].data);
        end
      end else begin
        chk("idle_we", mem_we, 0);
      end
      if (cpu_ack) score(1'b0, cpu_rdata); else chk("cpu_rdata_zero", cpu_rdata, 0);
      if (dbg_ack) score(1'b1, dbg_rdata); else chk("dbg_rdata_zero", dbg_rdata, 0);
      // Advance: an ack hands over to a waiting other port; otherwise arbitrate when free.
      if (cyc == m_ack_cyc) begin
        m_last = m_cur;
        if (m_cur ? cpu_req : dbg_req) begin
          m_cur     = ~m_cur;
          m_ack_cyc = cyc + 2;
          m_cnt     = sat_inc(m_cnt);
        end else begin
          m_ack_cyc = -1;
        end
      end else if (m_ack_cyc < 0) begin
        if (cpu_req && dbg_req) begin
          m_cur     = ~m_last;
          m_cnt     = sat_inc(m_cnt);
          m_ack_cyc = cyc + 2;
        end else if (cpu_req || dbg_req) begin
          m_cur     = dbg_req;
          m_ack_cyc = cyc + 2;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic sel, input logic v);
    if (sel) dbg_req = v; else cpu_req = v;
  endtask

  // Issue one access (aligned just after a rising edge) and wait for its ack.
  task automatic do_access(input logic sel, input logic we, input logic [7:0] a,
                           input logic [31:0] d);
    txn_t t;
    bit   got;
    t.we = we; t.addr = a; t.data = d;
    if (sel) begin
      dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1; q_dbg.push_back(t);
    end else begin
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; q_cpu.push_back(t);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = sel ? dbg_ack : cpu_ack;
    end
    if (!got) chk(sel ? "dbg_ack_timeout" : "cpu_ack_timeout", 0, 1);
    step();
  endtask

  task automatic run_port(input logic sel, input int n, input int maxgap);
    int gap;
    for (int i = 0; i < n; i++) begin
      do_access(sel, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
      gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      if (gap > 0) begin
        set_req(sel, 1'b0);
        repeat (gap) step();
      end
    end
    set_req(sel, 1'b0);
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Single CPU read of preloaded word.
    do_access(1'b0, 1'b0, 8'h10, 32'h0);
    cpu_req = 1'b0;
    repeat (2) step();

    // Debug write followed by CPU read-back.
    do_access(1'b1, 1'b1, 8'h20, 32'h12345678);
    dbg_req = 1'b0;
    step();
    do_access(1'b0, 1'b0, 8'h20, 32'h0);
    cpu_req = 1'b0;
    repeat (2) step();

    // Both ports hammering back to back: strict alternation.
    fork
      run_port(1'b0, 5, 0);
      run_port(1'b1, 5, 0);
    join
    repeat (3) step();

    // Reset during the GRANT of a debug write.
    dbg_we = 1'b1; dbg_addr = 8'h30; dbg_wdata = 32'hCAFEF00D; dbg_req = 1'b1;
    begin
      txn_t t;
      t.we = 1'b1; t.addr = 8'h30; t.data = 32'hCAFEF00D;
      q_dbg.push_back(t);
    end
    step();
    chk("grant_we_before_rst", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("mem_we_drop_on_rst", mem_we, 0);
    chk("dbg_ack_on_rst", dbg_ack, 0);
    dbg_req = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("cnt_after_rst", conflict_cnt, 0);

    // Contest straight after reset: CPU first, debug handed over from RESP.
    fork
      begin do_access(1'b0, 1'b0, 8'h30, 32'h0); cpu_req = 1'b0; end
      begin do_access(1'b1, 1'b0, 8'h10, 32'h0); dbg_req = 1'b0; end
    join
    step();
    chk("cnt_after_pair", conflict_cnt, 2);

    // Randomized traffic with idle gaps.
    fork
      run_port(1'b0, 30, 3);
      run_port(1'b1, 30, 3);
    join
    repeat (3) step();

    // Saturation of the contest counter.
    force dut.r_conflict_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    repeat (2) step();
    release dut.r_conflict_cnt;
    step();
    fork
      begin do_access(1'b0, 1'b0, 8'h01, 32'h0); cpu_req = 1'b0; end
      begin do_access(1'b1, 1'b0, 8'h02, 32'h0); dbg_req = 1'b0; end
    join
    step();
    chk("cnt_saturated", conflict_cnt, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter AW, default 8, word-address width.
REQ-002 SHALL provide parameter DW, default 32, data width.
REQ-003 SHALL provide the following ports:
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- cpu_req  input  1  CPU access request; held until cpu_ack.
- cpu_we  input  1  CPU write (1) / read (0).
- cpu_addr  input  AW  CPU word address.
- cpu_wdata  input  DW  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse to CPU.
- cpu_rdata  output  DW  CPU read data, valid with cpu_ack.
- cpu_stall  output  1  freezes the control FSM while the CPU access is outstanding.
- dbg_req  input  1  debug/loader request; held until dbg_ack.
- dbg_we  input  1  debug write (1) / read (0).
- dbg_addr  input  AW  debug word address.
- dbg_wdata  input  DW  debug write data.
- dbg_ack  output  1  one-cycle completion pulse to debug port.
- dbg_rdata  output  DW  debug read data, valid with dbg_ack.
- mem_addr  output  AW  shared single-port RAM address.
- mem_we  output  1  shared RAM write enable.
- mem_wdata  output  DW  shared RAM write data.
- mem_rdata  input  DW  RAM read data, one cycle after address.
- conflict_cnt  output  16  count of contested arbitrations.

Function
REQ-004 SHALL implement FSM states IDLE, GRANT, RESP, plus a 1-bit owner register (CPU/DBG) and a 1-bit last_owner register.
REQ-005 In IDLE with exactly one req high, SHALL set owner to that requester and enter GRANT next cycle.
REQ-006 In IDLE with both req high, SHALL grant the requester that is not last_owner (round-robin) and increment conflict_cnt.
REQ-007 In IDLE with no req, SHALL remain in IDLE.
REQ-008 In GRANT, SHALL drive mem_addr/mem_wdata from the owner's inputs and mem_we = owner's we, then enter RESP unconditionally.
REQ-009 Outside GRANT, mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold the owner's values (don't-care to RAM).
REQ-010 In RESP, SHALL pulse the owner's ack for exactly one cycle, route mem_rdata to the owner's rdata, and set last_owner = owner.
REQ-011 From RESP, if the non-owner's req is high, SHALL enter GRANT with owner switched, without passing IDLE, and increment conflict_cnt.
REQ-012 From RESP, if the non-owner's req is low, SHALL enter IDLE; the owner's own req in RESP is ignored.
REQ-013 Latency: req sampled high in IDLE at edge k -> GRANT in cycle k+1 -> ack in cycle k+2; minimum 3 cycles between successive accesses of one requester, 2 cycles between alternating requesters.
REQ-014 Write completes at the GRANT->RESP edge; ack for writes SHALL follow the same timing as for reads, and rdata SHALL be don't-care.
REQ-015 cpu_rdata/dbg_rdata SHALL be 0 whenever the respective ack is 0.
REQ-016 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational).
REQ-017 conflict_cnt SHALL saturate at 16'hFFFF and not wrap.
REQ-018 A req dropped before its ack (protocol violation) SHALL NOT abort an in-progress GRANT/RESP; the sequence completes and the ack is still issued.

Reset
REQ-019 On rst_n low, SHALL immediately (asynchronously) set state = IDLE, owner = CPU, last_owner = DBG, conflict_cnt = 0, mem_we = 0, both acks = 0.
REQ-020 Reset asserted during GRANT SHALL drop mem_we within the same cycle; no ack SHALL be issued for the aborted access.
REQ-021 After rst_n deasserts, the first contested arbitration SHALL go to the CPU.

Verification
REQ-022 Scenario: CPU read only, addr 8'h10, RAM holds 32'hDEADBEEF -> mem_we 0 in GRANT, cpu_ack at k+2 with cpu_rdata 32'hDEADBEEF, cpu_stall high for cycles k..k+1.
REQ-023 Scenario: dbg write addr 8'h20, data 32'h12345678, then CPU read 8'h20 -> mem_we 1 for one cycle; CPU later reads 32'h12345678.
REQ-024 Scenario: both req high from IDLE after reset -> CPU acked first, dbg GRANT directly from RESP, dbg_ack 2 cycles after cpu_ack, conflict_cnt = 2.
REQ-025 Scenario: both req held continuously for 10 accesses -> acks strictly alternate CPU, DBG, CPU, ...; conflict_cnt increments per arbitration.
REQ-026 Scenario: rst_n pulled low in GRANT of a dbg write -> mem_we falls immediately, no dbg_ack, state IDLE, conflict_cnt 0.
REQ-027 Scenario: force conflict_cnt to 16'hFFFF, then issue a contested arbitration -> conflict_cnt stays 16'hFFFF.
